// File: rtl/devil_multi_window.sv
// rtl/devil_multi_window.sv - multi-window snoop-response injector with per-strobe delays
module devil_multi_window #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_ACE_DATA_WIDTH   = 128,
    parameter int C_ACE_ADDR_WIDTH   = 44,
    parameter int NUM_WINDOWS        = 4,
    parameter int CNT_WIDTH          = 64,
    parameter int CYCLES_PER_UNIT    = 150,
    parameter int DEVIL_EN           = 10
) (
    input  logic                                      ace_aclk,
    input  logic                                      ace_areset,
    input  logic [3:0]                                acsnoop,
    input  logic [C_ACE_ADDR_WIDTH-1:0]               acaddr,
    input  logic [3:0]                                i_snoop_state,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             i_control_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             i_acsnoop_reg,
    input  logic [NUM_WINDOWS*C_ACE_ADDR_WIDTH-1:0]   i_base_addr_flat,
    input  logic [NUM_WINDOWS*C_ACE_ADDR_WIDTH-1:0]   i_addr_size_flat,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             i_delay_cr_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             i_delay_cd_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             i_delay_last_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             i_shot_count_reg,
    input  logic                                      i_status_clr,
    output logic [3:0]                                o_fsm_devil_state,
    output logic [C_S_AXI_DATA_WIDTH-1:0]             o_status_reg,
    output logic [31:0]                               o_hit_count,
    output logic [NUM_WINDOWS-1:0]                    o_win_hit,
    output logic [C_ACE_DATA_WIDTH-1:0]               o_rdata,
    output logic [4:0]                                o_crresp,
    output logic                                      o_crvalid,
    output logic                                      o_cdvalid,
    output logic                                      o_cdlast
);
    localparam int AW = C_ACE_ADDR_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FILTER  = 4'd1,
        S_RESPOND = 4'd2,
        S_DELAY   = 4'd3,
        S_HOLD    = 4'd4,
        S_RELEASE = 4'd5
    } state_t;

    state_t                          r_state;
    logic [CNT_WIDTH-1:0]            r_cnt;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_shots;
    logic [31:0]                     r_hit_count;
    logic [NUM_WINDOWS-1:0]          r_win_hit;
    logic [C_ACE_DATA_WIDTH-1:0]     r_rdata;
    logic [4:0]                      r_crresp;
    logic                            r_crvalid, r_cdvalid, r_cdlast;
    logic                            r_done, r_busy, r_clr_pend;

    logic                            w_en, w_ac_fen, w_addr_fen;
    logic                            w_cr_den, w_cd_den, w_last_den;
    logic [1:0]                      w_mode;
    logic [4:0]                      w_crresp;
    logic [NUM_WINDOWS-1:0]          w_mask, w_win_hit;
    logic                            w_pass;
    logic [CNT_WIDTH-1:0]            w_cnt_nxt, w_tgt_cr, w_tgt_cd, w_tgt_last;
    logic                            w_cr_imm, w_cd_imm, w_last_imm;
    logic                            w_cr_set, w_cd_set, w_last_set;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_shot_n;
    logic                            w_unused;

    assign w_en       = i_control_reg[0];
    assign w_mode     = i_control_reg[2:1];
    assign w_crresp   = i_control_reg[7:3];
    assign w_ac_fen   = i_control_reg[8];
    assign w_addr_fen = i_control_reg[9];
    assign w_cr_den   = i_control_reg[10];
    assign w_cd_den   = i_control_reg[11];
    assign w_last_den = i_control_reg[12];
    assign w_mask     = i_control_reg[13 +: NUM_WINDOWS];
    assign w_unused   = &{1'b0, i_control_reg[C_S_AXI_DATA_WIDTH-1:13+NUM_WINDOWS],
                          i_acsnoop_reg[C_S_AXI_DATA_WIDTH-1:4]};

    // Bounds are compared one bit wider so a window ending at the top of the space cannot wrap to 0
    always_comb begin
        w_win_hit = '0;
        for (int k = 0; k < NUM_WINDOWS; k++) begin
            if (w_mask[k] && (i_addr_size_flat[k*AW +: AW] != '0) &&
                ({1'b0, acaddr} >= {1'b0, i_base_addr_flat[k*AW +: AW]}) &&
                ({1'b0, acaddr} < ({1'b0, i_base_addr_flat[k*AW +: AW]} +
                                   {1'b0, i_addr_size_flat[k*AW +: AW]})))
                w_win_hit[k] = 1'b1;
        end
    end

    assign w_pass = (!w_ac_fen || (acsnoop == i_acsnoop_reg[3:0])) &&
                    (!w_addr_fen || (|w_win_hit));

    assign w_cnt_nxt  = r_cnt + CNT_WIDTH'(1);
    assign w_tgt_cr   = CNT_WIDTH'(CYCLES_PER_UNIT) * CNT_WIDTH'(i_delay_cr_reg);
    assign w_tgt_cd   = CNT_WIDTH'(CYCLES_PER_UNIT) * CNT_WIDTH'(i_delay_cd_reg);
    assign w_tgt_last = CNT_WIDTH'(CYCLES_PER_UNIT) * CNT_WIDTH'(i_delay_last_reg);

    assign w_cr_imm   = !w_cr_den   || (i_delay_cr_reg   == '0);
    assign w_cd_imm   = !w_cd_den   || (i_delay_cd_reg   == '0);
    assign w_last_imm = !w_last_den || (i_delay_last_reg == '0);

    // Dropping en releases every pending strobe so the response channel cannot stall
    assign w_cr_set   = r_crvalid || !w_en || (w_cnt_nxt == w_tgt_cr);
    assign w_cd_set   = r_cdvalid || !w_en || (w_cnt_nxt == w_tgt_cd);
    assign w_last_set = r_cdlast  || !w_en || (w_cnt_nxt == w_tgt_last);

    assign w_shot_n = (i_shot_count_reg == '0) ? C_S_AXI_DATA_WIDTH'(1) : i_shot_count_reg;

    always_ff @(posedge ace_aclk) begin
        if (ace_areset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shots     <= '0;
            r_hit_count <= '0;
            r_win_hit   <= '0;
            r_rdata     <= '0;
            r_crresp    <= '0;
            r_crvalid   <= 1'b0;
            r_cdvalid   <= 1'b0;
            r_cdlast    <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_clr_pend  <= 1'b0;
        end else begin
            if (i_status_clr && (r_state != S_IDLE))
                r_clr_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_clr_pend <= 1'b0;
                    if (i_status_clr || r_clr_pend || (w_mode == 2'b00)) begin
                        r_done  <= 1'b0;
                        r_shots <= '0;
                    end
                    if ((i_snoop_state == 4'(DEVIL_EN)) && w_en && (w_mode != 2'b00) && !r_done)
                        r_state <= S_FILTER;
                end
                S_FILTER: begin
                    if (w_pass) begin
                        r_win_hit <= w_win_hit;
                        r_crresp  <= w_crresp;
                        r_rdata   <= C_ACE_DATA_WIDTH'(w_crresp);
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_crvalid <= w_cr_imm;
                        r_cdvalid <= w_cd_imm;
                        r_cdlast  <= w_last_imm;
                        r_shots   <= r_shots + C_S_AXI_DATA_WIDTH'(1);
                        if (r_hit_count != 32'hFFFF_FFFF)
                            r_hit_count <= r_hit_count + 32'd1;
                        r_state   <= S_RESPOND;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_RESPOND, S_DELAY: begin
                    r_cnt     <= w_cnt_nxt;
                    r_crvalid <= w_cr_set;
                    r_cdvalid <= w_cd_set;
                    r_cdlast  <= w_last_set;
                    r_state   <= (w_cr_set && w_cd_set && w_last_set) ? S_HOLD : S_DELAY;
                end
                S_HOLD: begin
                    if (i_snoop_state != 4'(DEVIL_EN)) begin
                        r_crvalid <= 1'b0;
                        r_cdvalid <= 1'b0;
                        r_cdlast  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if ((w_mode == 2'b01) || ((w_mode == 2'b11) && (r_shots >= w_shot_n)))
                        r_done <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_fsm_devil_state = r_state;
    assign o_status_reg      = {{(C_S_AXI_DATA_WIDTH-2){1'b0}}, r_busy, r_done};
    assign o_hit_count       = r_hit_count;
    assign o_win_hit         = r_win_hit;
    assign o_rdata           = r_rdata;
    assign o_crresp          = r_crresp;
    assign o_crvalid         = r_crvalid;
    assign o_cdvalid         = r_cdvalid;
    assign o_cdlast          = r_cdlast;
endmodule

// File: tb/tb_devil_multi_window.sv
// tb/tb_devil_multi_window.sv - directed, table-driven bench for devil_multi_window
module tb_devil_multi_window;
    localparam int DW  = 32;
    localparam int ADW = 128;
    localparam int AW  = 44;
    localparam int NW  = 4;

    logic              clk = 1'b0;
    logic              areset;
    logic [3:0]        acsnoop;
    logic [AW-1:0]     acaddr;
    logic [3:0]        snoop_state;
    logic [DW-1:0]     control_reg, acsnoop_reg;
    logic [NW*AW-1:0]  base_flat, size_flat;
    logic [DW-1:0]     delay_cr, delay_cd, delay_last, shot_reg;
    logic              status_clr;
    logic [3:0]        fsm_state;
    logic [DW-1:0]     status;
    logic [31:0]       hit_count;
    logic [NW-1:0]     win_hit;
    logic [ADW-1:0]    rdata;
    logic [4:0]        crresp;
    logic              crvalid, cdvalid, cdlast;

    int tests = 0;
    int fails = 0;

    devil_multi_window dut (
        .ace_aclk(clk), .ace_areset(areset), .acsnoop(acsnoop), .acaddr(acaddr),
        .i_snoop_state(snoop_state), .i_control_reg(control_reg), .i_acsnoop_reg(acsnoop_reg),
        .i_base_addr_flat(base_flat), .i_addr_size_flat(size_flat),
        .i_delay_cr_reg(delay_cr), .i_delay_cd_reg(delay_cd), .i_delay_last_reg(delay_last),
        .i_shot_count_reg(shot_reg), .i_status_clr(status_clr),
        .o_fsm_devil_state(fsm_state), .o_status_reg(status), .o_hit_count(hit_count),
        .o_win_hit(win_hit), .o_rdata(rdata), .o_crresp(crresp),
        .o_crvalid(crvalid), .o_cdvalid(cdvalid), .o_cdlast(cdlast)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ac_f;
        logic          addr_f;
        logic [NW-1:0] mask;
        logic [3:0]    snoop;
        logic [AW-1:0] addr;
        logic          exp_pass;
        logic [NW-1:0] exp_win;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_ctrl(input logic en, input logic [1:0] mode,
                                              input logic [4:0] rsp, input logic ac_f,
                                              input logic addr_f, input logic cr_d,
                                              input logic cd_d, input logic last_d,
                                              input logic [NW-1:0] mask);
        logic [DW-1:0] c;
        c = '0;
        c[0] = en; c[2:1] = mode; c[7:3] = rsp; c[8] = ac_f; c[9] = addr_f;
        c[10] = cr_d; c[11] = cd_d; c[12] = last_d; c[13 +: NW] = mask;
        return c;
    endfunction

    task automatic do_reset();
        areset = 1'b1;
        tick(); tick();
        areset = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (fsm_state != 4'd0 && n < 3000) begin
            tick();
            n++;
        end
        check("idle_reached", 64'(fsm_state), 64'd0);
    endtask

    // One snoop with all delays disabled; returns the state seen two cycles after entry
    task automatic snoop_once(output logic [3:0] st);
        snoop_state = 4'd10;
        tick(); tick();
        st = fsm_state;
        snoop_state = 4'd0;
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 64'(fsm_state), 64'd0);
        check({tag, "_status"}, 64'(status), 64'd0);
        check({tag, "_hits"}, 64'(hit_count), 64'd0);
        check({tag, "_win"}, 64'(win_hit), 64'd0);
        check({tag, "_rsp"}, {58'd0, crresp, |rdata}, 64'd0);
        check({tag, "_strobes"}, {61'd0, crvalid, cdvalid, cdlast}, 64'd0);
    endtask

    initial begin
        logic [3:0] st;
        int cd_at, cr_at, exp_hits;

        areset = 1'b0; acsnoop = '0; acaddr = '0; snoop_state = '0;
        control_reg = '0; acsnoop_reg = 32'h7; status_clr = 1'b0;
        delay_cr = '0; delay_cd = '0; delay_last = '0; shot_reg = '0;
        base_flat = '0; size_flat = '0;
        base_flat[0*AW +: AW] = 44'h1000;        size_flat[0*AW +: AW] = 44'h1000;
        base_flat[1*AW +: AW] = 44'h3000;        size_flat[1*AW +: AW] = 44'h100;
        base_flat[2*AW +: AW] = 44'h8000;        size_flat[2*AW +: AW] = 44'h100;
        base_flat[3*AW +: AW] = 44'hFFF_FFFF_FF00; size_flat[3*AW +: AW] = 44'h200;

        vecs[0]  = '{1'b0, 1'b1, 4'b0101, 4'h0, 44'h1FFF,          1'b1, 4'b0001};
        vecs[1]  = '{1'b0, 1'b1, 4'b0101, 4'h0, 44'h2000,          1'b0, 4'b0000};
        vecs[2]  = '{1'b0, 1'b1, 4'b0101, 4'h0, 44'h80FF,          1'b1, 4'b0100};
        vecs[3]  = '{1'b0, 1'b1, 4'b0101, 4'h0, 44'h3000,          1'b0, 4'b0000};
        vecs[4]  = '{1'b0, 1'b1, 4'b1000, 4'h0, 44'hFFF_FFFF_FFFF, 1'b1, 4'b1000};
        vecs[5]  = '{1'b0, 1'b1, 4'b1000, 4'h0, 44'h0,             1'b0, 4'b0000};
        vecs[6]  = '{1'b0, 1'b1, 4'b0101, 4'h0, 44'h1000,          1'b1, 4'b0001};
        vecs[7]  = '{1'b0, 1'b1, 4'b0010, 4'h0, 44'h3000,          1'b1, 4'b0010};
        vecs[8]  = '{1'b0, 1'b1, 4'b0101, 4'h0, 44'h0FFF,          1'b0, 4'b0000};
        vecs[9]  = '{1'b1, 1'b0, 4'b0000, 4'h7, 44'h1234,          1'b1, 4'b0000};
        vecs[10] = '{1'b1, 1'b0, 4'b0000, 4'h3, 44'h1234,          1'b0, 4'b0000};
        vecs[11] = '{1'b1, 1'b1, 4'b0001, 4'h7, 44'h1800,          1'b1, 4'b0001};
        vecs[12] = '{1'b1, 1'b1, 4'b0001, 4'h3, 44'h1800,          1'b0, 4'b0000};
        vecs[13] = '{1'b0, 1'b0, 4'b0000, 4'h0, 44'h0,             1'b1, 4'b0000};

        do_reset();
        check_all_zero("reset");

        // One-shot, no filters, immediate strobes
        control_reg = mk_ctrl(1'b1, 2'b01, 5'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
        snoop_state = 4'd10;
        tick(); tick();
        check("os_state_respond", 64'(fsm_state), 64'd2);
        check("os_strobes", {61'd0, crvalid, cdvalid, cdlast}, 64'd7);
        check("os_crresp", 64'(crresp), 64'd1);
        check("os_rdata", 64'(rdata), 64'd1);
        check("os_busy", 64'(status), 64'd2);
        snoop_state = 4'd0;
        tick();
        check("os_state_hold", 64'(fsm_state), 64'd4);
        tick();
        check("os_state_release", 64'(fsm_state), 64'd5);
        check("os_release_strobes", {61'd0, crvalid, cdvalid, cdlast}, 64'd0);
        check("os_release_status", 64'(status), 64'd0);
        tick();
        check("os_idle", 64'(fsm_state), 64'd0);
        check("os_done", 64'(status), 64'd1);
        snoop_state = 4'd10;
        tick(); tick();
        check("os_second_ignored", 64'(fsm_state), 64'd0);
        snoop_state = 4'd0;
        check("os_hit_count", 64'(hit_count), 64'd1);

        // Filter table in continuous mode
        do_reset();
        exp_hits = 0;
        for (int i = 0; i < 14; i++) begin
            control_reg = mk_ctrl(1'b1, 2'b10, 5'h3, vecs[i].ac_f, vecs[i].addr_f,
                                  1'b0, 1'b0, 1'b0, vecs[i].mask);
            acsnoop = vecs[i].snoop;
            acaddr  = vecs[i].addr;
            snoop_state = 4'd10;
            tick(); tick();
            check($sformatf("vec%0d_state", i), 64'(fsm_state), vecs[i].exp_pass ? 64'd2 : 64'd0);
            if (vecs[i].exp_pass) begin
                exp_hits++;
                check($sformatf("vec%0d_win", i), 64'(win_hit), 64'(vecs[i].exp_win));
                check($sformatf("vec%0d_crresp", i), 64'(crresp), 64'd3);
            end
            snoop_state = 4'd0;
            wait_idle();
        end
        check("table_hit_count", 64'(hit_count), 64'(exp_hits));
        check("table_no_done", 64'(status), 64'd0);

        // Independent delays, continuous mode
        do_reset();
        acaddr = '0; acsnoop = '0;
        control_reg = mk_ctrl(1'b1, 2'b10, 5'h2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0);
        delay_cr = 32'd2; delay_cd = 32'd1; delay_last = 32'd0;
        for (int s = 0; s < 3; s++) begin
            snoop_state = 4'd10;
            tick(); tick();
            check("dly_respond", 64'(fsm_state), 64'd2);
            check("dly_respond_strobes", {61'd0, crvalid, cdvalid, cdlast}, 64'd1);
            cd_at = -1; cr_at = -1;
            for (int k = 1; k <= 400 && cr_at < 0; k++) begin
                tick();
                if (cdvalid && cd_at < 0) cd_at = k;
                if (crvalid && cr_at < 0) cr_at = k;
            end
            check("dly_cdvalid_cycle", 64'(cd_at), 64'd150);
            check("dly_crvalid_cycle", 64'(cr_at), 64'd300);
            check("dly_hold", 64'(fsm_state), 64'd4);
            snoop_state = 4'd0;
            wait_idle();
        end
        check("dly_hit_count", 64'(hit_count), 64'd3);
        check("dly_no_done", 64'(status), 64'd0);

        // N-shot with re-arm
        do_reset();
        delay_cr = '0; delay_cd = '0;
        control_reg = mk_ctrl(1'b1, 2'b11, 5'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
        shot_reg = 32'd3;
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 3; s++) begin
                snoop_once(st);
                check("ns_shot_state", 64'(st), 64'd2);
                check("ns_done", 64'(status), (s == 2) ? 64'd1 : 64'd0);
            end
            snoop_once(st);
            check("ns_ignored", 64'(st), 64'd0);
            status_clr = 1'b1;
            tick();
            status_clr = 1'b0;
            check("ns_cleared", 64'(status), 64'd0);
        end
        check("ns_hit_count", 64'(hit_count), 64'd6);

        // Mid-delay disable
        do_reset();
        control_reg = mk_ctrl(1'b1, 2'b10, 5'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0);
        delay_cr = 32'd10;
        snoop_state = 4'd10;
        tick(); tick();
        for (int k = 0; k < 50; k++) tick();
        check("md_in_delay", 64'(fsm_state), 64'd3);
        check("md_cr_low", 64'(crvalid), 64'd0);
        control_reg[0] = 1'b0;
        tick();
        check("md_cr_forced", 64'(crvalid), 64'd1);
        check("md_hold", 64'(fsm_state), 64'd4);
        snoop_state = 4'd0;
        wait_idle();

        // Mid-delay reset
        control_reg[0] = 1'b1;
        snoop_state = 4'd10;
        tick(); tick(); tick(); tick();
        check("mr_in_delay", 64'(fsm_state), 64'd3);
        areset = 1'b1;
        tick();
        check_all_zero("mr");
        areset = 1'b0;
        snoop_state = 4'd0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
